// File: rtl/fir_frame_sequencer.sv
// Host-side frame sequencer for the FIR engine: loads input samples into
// shared memory, kicks the engine, then streams the result region back out.
module fir_frame_sequencer #(
   parameter int ADDR_W      = 10,
   parameter int DATA_W      = 8,
   parameter int IN_BASE     = 0,
   parameter int OUT_BASE    = 512,
   parameter int MAX_SAMPLES = 512
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              go,
   input  logic [ADDR_W-1:0] cfg_count,
   output logic              busy,
   output logic              frame_done,
   input  logic              s_valid,
   output logic              s_ready,
   input  logic [DATA_W-1:0] s_data,
   output logic              m_valid,
   input  logic              m_ready,
   output logic [DATA_W-1:0] m_data,
   output logic              m_last,
   output logic              fir_start,
   output logic [ADDR_W-1:0] fir_input_addr,
   output logic [ADDR_W-1:0] fir_output_addr,
   output logic [ADDR_W-1:0] fir_sample_count,
   input  logic              fir_done,
   output logic              fir_grant,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              mem_we,
   input  logic [DATA_W-1:0] mem_rdata
);

   typedef enum logic [2:0] {
      IDLE, LOAD, KICK, WAIT, RD_ADDR, RD_CAPT, HOLD, DONE
   } state_t;

   localparam logic [ADDR_W-1:0] IN_A    = ADDR_W'(IN_BASE);
   localparam logic [ADDR_W-1:0] OUT_A   = ADDR_W'(OUT_BASE);
   localparam logic [ADDR_W-1:0] MAX_CNT = ADDR_W'(MAX_SAMPLES);
   localparam logic [ADDR_W-1:0] ONE     = ADDR_W'(1);

   state_t            state;
   state_t            state_nx;
   logic [ADDR_W-1:0] cnt;
   logic [ADDR_W-1:0] idx;
   logic [ADDR_W-1:0] cfg_eff;
   logic              idx_last;

   assign cfg_eff  = (cfg_count > MAX_CNT) ? MAX_CNT : cfg_count;
   assign idx_last = (idx == cnt - ONE);

   assign fir_input_addr   = IN_A;
   assign fir_output_addr  = OUT_A;
   assign fir_sample_count = cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE: begin
            if (go) state_nx = (cfg_eff == '0) ? DONE : LOAD;
         end
         LOAD: begin
            if (s_valid && idx_last) state_nx = KICK;
         end
         KICK: state_nx = WAIT;
         // Done seen in KICK may be left over from the previous frame.
         WAIT: begin
            if (fir_done) state_nx = RD_ADDR;
         end
         RD_ADDR: state_nx = RD_CAPT;
         RD_CAPT: state_nx = HOLD;
         HOLD: begin
            if (m_ready) state_nx = m_last ? DONE : RD_ADDR;
         end
         DONE: state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_comb begin
      busy       = (state != IDLE);
      frame_done = 1'b0;
      s_ready    = 1'b0;
      fir_start  = 1'b0;
      fir_grant  = 1'b0;
      mem_addr   = '0;
      mem_wdata  = '0;
      mem_we     = 1'b0;
      unique case (state)
         LOAD: begin
            s_ready   = 1'b1;
            mem_addr  = IN_A + idx;
            mem_wdata = s_data;
            mem_we    = s_valid;
         end
         KICK: begin
            fir_start = 1'b1;
            fir_grant = 1'b1;
         end
         WAIT:    fir_grant = 1'b1;
         RD_ADDR: mem_addr  = OUT_A + idx;
         RD_CAPT: mem_addr  = OUT_A + idx;
         DONE:    frame_done = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt     <= '0;
         idx     <= '0;
         m_valid <= 1'b0;
         m_data  <= '0;
         m_last  <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (go) begin
                  cnt <= cfg_eff;
                  idx <= '0;
               end
            end
            LOAD: begin
               if (s_valid) idx <= idx_last ? '0 : idx + ONE;
            end
            RD_CAPT: begin
               m_data  <= mem_rdata;
               m_valid <= 1'b1;
               m_last  <= idx_last;
            end
            HOLD: begin
               if (m_ready) begin
                  m_valid <= 1'b0;
                  if (!m_last) idx <= idx + ONE;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_fir_frame_sequencer.sv
// Scoreboard bench for fir_frame_sequencer with a behavioural engine and
// shared sample memory; results are predicted as (x*9)>>8 per sample.
module tb_fir_frame_sequencer;

   localparam int AW = 10;
   localparam int DW = 8;
   localparam int MS = 512;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          go = 1'b0;
   logic [AW-1:0] cfg_count = '0;
   logic          busy;
   logic          frame_done;
   logic          s_valid = 1'b0;
   logic          s_ready;
   logic [DW-1:0] s_data = '0;
   logic          m_valid;
   logic          m_ready = 1'b0;
   logic [DW-1:0] m_data;
   logic          m_last;
   logic          fir_start;
   logic [AW-1:0] fir_input_addr;
   logic [AW-1:0] fir_output_addr;
   logic [AW-1:0] fir_sample_count;
   logic          fir_done = 1'b0;
   logic          fir_grant;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic          mem_we;
   logic [DW-1:0] mem_rdata = '0;

   typedef struct packed {
      logic          l;
      logic [DW-1:0] d;
   } exp_t;

   exp_t exq[$];
   int   checks = 0;
   int   errors = 0;
   int   wr_idx = 0;
   int   start_cnt = 0;
   int   we_cnt = 0;
   int   done_cnt = 0;
   int   outs_in_frame = 0;
   int   stall = 0;
   bit   rnd_ready = 1'b0;
   bit   bp_test = 1'b0;

   logic [DW-1:0] mem [0:1023];
   logic          eng_run = 1'b0;
   int            eng_timer = 0;
   int            eng_cnt = 0;

   fir_frame_sequencer dut (
      .clk              (clk),
      .rst              (rst),
      .go               (go),
      .cfg_count        (cfg_count),
      .busy             (busy),
      .frame_done       (frame_done),
      .s_valid          (s_valid),
      .s_ready          (s_ready),
      .s_data           (s_data),
      .m_valid          (m_valid),
      .m_ready          (m_ready),
      .m_data           (m_data),
      .m_last           (m_last),
      .fir_start        (fir_start),
      .fir_input_addr   (fir_input_addr),
      .fir_output_addr  (fir_output_addr),
      .fir_sample_count (fir_sample_count),
      .fir_done         (fir_done),
      .fir_grant        (fir_grant),
      .mem_addr         (mem_addr),
      .mem_wdata        (mem_wdata),
      .mem_we           (mem_we),
      .mem_rdata        (mem_rdata)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual %0h required %0h", name, act, exp);
      end
   endtask

   task automatic fail_now(input string name);
      checks++;
      errors++;
      $display("FAIL %s timeout", name);
   endtask

   // Shared memory (host port, 1-cycle read) plus engine model.
   always @(posedge clk) begin
      if (!fir_grant && mem_we) mem[mem_addr] <= mem_wdata;
      mem_rdata <= mem[mem_addr];
      if (fir_start) begin
         fir_done  <= 1'b0;
         eng_run   <= 1'b1;
         eng_cnt   <= int'(fir_sample_count);
         eng_timer <= $urandom_range(3, 15);
      end else if (eng_run) begin
         if (eng_timer == 0) begin
            for (int i = 0; i < eng_cnt; i++)
               mem[AW'(int'(fir_output_addr) + i)] <=
                  8'((int'(mem[AW'(int'(fir_input_addr) + i)]) * 9) >> 8);
            fir_done <= 1'b1;
            eng_run  <= 1'b0;
         end else begin
            eng_timer <= eng_timer - 1;
         end
      end
   end

   always @(posedge clk) begin
      #1;
      if (bp_test && m_valid && outs_in_frame == 1 && stall < 7) begin
         m_ready = 1'b0;
         stall++;
      end else begin
         m_ready = rnd_ready ? ($urandom_range(0, 2) != 0) : 1'b1;
      end
   end

   logic [DW-1:0] pd;
   logic          pl;
   bit            pend = 1'b0;
   exp_t          e;

   always @(negedge clk) begin
      if (rst) begin
         pend = 1'b0;
      end else begin
         if (pend) begin
            chk("hold_valid", 32'(m_valid), 32'd1);
            chk("hold_data", {m_last, m_data}, {pl, pd});
         end
         pend = m_valid && !m_ready;
         pd   = m_data;
         pl   = m_last;
         if (m_valid && m_ready) begin
            if (exq.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_out actual %0h required none",
                        m_data);
            end else begin
               e = exq.pop_front();
               chk("out_data", 32'(m_data), 32'(e.d));
               chk("out_last", 32'(m_last), 32'(e.l));
            end
            outs_in_frame++;
         end
         if (mem_we) begin
            chk("wr_addr", 32'(mem_addr), 32'(wr_idx));
            chk("wr_data", 32'(mem_wdata), 32'(s_data));
            wr_idx++;
            we_cnt++;
         end
         if (fir_start) start_cnt++;
         if (frame_done) begin
            done_cnt++;
            outs_in_frame = 0;
         end
      end
   end

   task automatic run_frame(input int cfg, input int mode,
                            input bit mid_go, input bit abort);
      int eff, s0, d0, w0, n, gap;
      logic [DW-1:0] x;
      eff = (cfg > MS) ? MS : cfg;
      s0 = start_cnt;
      d0 = done_cnt;
      w0 = we_cnt;
      wr_idx = 0;
      stall = 0;
      go = 1'b1;
      cfg_count = AW'(cfg);
      @(posedge clk); #1;
      go = 1'b0;
      cfg_count = AW'($urandom);
      chk("busy_after_go", 32'(busy), 32'd1);
      if (eff == 0) chk("zero_done_now", 32'(frame_done), 32'd1);
      else chk("sample_count", 32'(fir_sample_count), 32'(eff));
      for (int i = 0; i < eff; i++) begin
         x = (mode == 1) ? 8'd128 :
             (mode == 2) ? 8'(i * 37 + 11) : 8'($urandom);
         exq.push_back('{l: (i == eff - 1), d: 8'((int'(x) * 9) >> 8)});
         if ($urandom_range(0, 3) == 0) begin
            s_valid = 1'b0;
            gap = $urandom_range(1, 3);
            repeat (gap) begin @(posedge clk); #1; end
         end
         s_valid = 1'b1;
         s_data = x;
         if (mid_go && i == 2) begin
            go = 1'b1;
            cfg_count = AW'(7);
         end
         n = 0;
         @(negedge clk);
         while (!s_ready && n < 50) begin @(negedge clk); n++; end
         if (!s_ready) fail_now("s_ready_wait");
         @(posedge clk); #1;
         go = 1'b0;
      end
      s_valid = 1'b0;
      if (mid_go) chk("count_after_mid_go", 32'(fir_sample_count), 32'(eff));
      if (abort) begin
         n = 0;
         while (!(fir_grant && !fir_start) && n < 20) begin
            @(negedge clk); n++;
         end
         if (n >= 20) fail_now("wait_state");
         #2 rst = 1'b1;
         #1 chk("rst_in_wait", {busy, fir_grant, m_valid, fir_start}, 32'd0);
         @(posedge clk); #1;
         rst = 1'b0;
         exq.delete();
         repeat (2) begin @(posedge clk); #1; end
         return;
      end
      n = 0;
      while (!frame_done && n < 6000) begin @(negedge clk); n++; end
      if (!frame_done) fail_now("frame_done_wait");
      repeat (2) begin @(posedge clk); #1; end
      chk("done_pulses", 32'(done_cnt - d0), 32'd1);
      chk("start_pulses", 32'(start_cnt - s0), (eff > 0) ? 32'd1 : 32'd0);
      chk("write_count", 32'(we_cnt - w0), 32'(eff));
      chk("queue_empty", 32'(exq.size()), 32'd0);
      chk("idle_after", 32'(busy), 32'd0);
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1;
      chk("reset_outputs",
          {busy, frame_done, s_ready, m_valid, m_last, fir_start,
           fir_grant, mem_we, fir_sample_count, mem_addr}, 32'd0);
      rst = 1'b0;
      @(posedge clk); #1;
      run_frame(5, 1, 1'b0, 1'b0);
      run_frame(5, 2, 1'b0, 1'b0);
      bp_test = 1'b1;
      run_frame(6, 0, 1'b0, 1'b0);
      bp_test = 1'b0;
      chk("bp_stall_cycles", 32'(stall), 32'd7);
      run_frame(0, 0, 1'b0, 1'b0);
      run_frame(6, 0, 1'b0, 1'b1);
      run_frame(3, 0, 1'b0, 1'b0);
      run_frame(9, 0, 1'b1, 1'b0);
      rnd_ready = 1'b1;
      for (int k = 0; k < 6; k++) run_frame($urandom_range(1, 40), 0, 1'b0, 1'b0);
      run_frame(1, 0, 1'b0, 1'b0);
      run_frame(1000, 0, 1'b0, 1'b0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
